// File: rtl/prog_clock_divider.sv
// Multi-channel programmable clock divider: pulse or toggle output per channel, with
// double-buffered divisor/mode updates applied at terminal count, on disable, or by sync.
module prog_clock_divider #(
   parameter int CHANNELS     = 4,
   parameter int WIDTH        = 16,
   parameter int DEFAULT_DIV  = 1,
   parameter int DEFAULT_MODE = 1,
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] en,
   input  logic                sync,
   input  logic                wr_en,
   input  logic [CW-1:0]       wr_chan,
   input  logic [WIDTH-1:0]    wr_div,
   input  logic                wr_mode,
   output logic [CHANNELS-1:0] divided,
   output logic [CHANNELS-1:0] pending
);

   localparam logic [WIDTH-1:0] RST_DIV  = WIDTH'(DEFAULT_DIV);
   localparam logic             RST_MODE = (DEFAULT_MODE != 0);

   logic [WIDTH-1:0]    r_cnt      [CHANNELS];
   logic [WIDTH-1:0]    r_act_div  [CHANNELS];
   logic [WIDTH-1:0]    r_shd_div  [CHANNELS];
   logic [CHANNELS-1:0] r_act_mode;
   logic [CHANNELS-1:0] r_shd_mode;
   logic [CHANNELS-1:0] r_pend;
   logic [CHANNELS-1:0] r_out;

   logic [WIDTH-1:0]    w_cnt      [CHANNELS];
   logic [WIDTH-1:0]    w_act_div  [CHANNELS];
   logic [WIDTH-1:0]    w_shd_div  [CHANNELS];
   logic [CHANNELS-1:0] w_act_mode;
   logic [CHANNELS-1:0] w_shd_mode;
   logic [CHANNELS-1:0] w_pend;
   logic [CHANNELS-1:0] w_out;
   logic [CHANNELS-1:0] w_hit;
   logic [CHANNELS-1:0] w_tc;
   logic [CHANNELS-1:0] w_mode_chg;
   logic [CHANNELS-1:0] w_apply;
   logic [CHANNELS-1:0] w_restart;

   // Per-channel next state; the shadow write is evaluated last so it always stays pending.
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         w_hit[i]      = wr_en && (wr_chan == CW'(i));
         w_tc[i]       = en[i] && (r_cnt[i] == r_act_div[i]);
         w_mode_chg[i] = r_pend[i] && (r_shd_mode[i] != r_act_mode[i]);
         w_apply[i]    = r_pend[i] && (sync || !en[i] || w_tc[i]);
         w_restart[i]  = sync || (!en[i] && r_pend[i]);

         w_cnt[i]      = r_cnt[i];
         w_act_div[i]  = r_act_div[i];
         w_act_mode[i] = r_act_mode[i];
         w_shd_div[i]  = r_shd_div[i];
         w_shd_mode[i] = r_shd_mode[i];
         w_pend[i]     = r_pend[i];
         w_out[i]      = r_out[i];

         if (w_apply[i]) begin
            w_act_div[i]  = r_shd_div[i];
            w_act_mode[i] = r_shd_mode[i];
            w_pend[i]     = 1'b0;
         end else begin
            w_act_div[i]  = r_act_div[i];
            w_act_mode[i] = r_act_mode[i];
         end

         if (w_restart[i]) begin
            w_cnt[i] = {WIDTH{1'b0}};
            w_out[i] = 1'b0;
         end else if (w_tc[i]) begin
            w_cnt[i] = {WIDTH{1'b0}};
            if (w_mode_chg[i]) begin
               w_out[i] = 1'b0;
            end else if (r_act_mode[i]) begin
               w_out[i] = 1'b1;
            end else begin
               w_out[i] = ~r_out[i];
            end
         end else if (en[i]) begin
            w_cnt[i] = r_cnt[i] + WIDTH'(1'b1);
            w_out[i] = r_act_mode[i] ? 1'b0 : r_out[i];
         end else begin
            w_out[i] = r_act_mode[i] ? 1'b0 : r_out[i];
         end

         if (w_hit[i]) begin
            w_shd_div[i]  = wr_div;
            w_shd_mode[i] = wr_mode;
            w_pend[i]     = 1'b1;
         end else begin
            w_shd_div[i]  = r_shd_div[i];
            w_shd_mode[i] = r_shd_mode[i];
         end
      end
   end

   // Channel state registers; rst overrides sync and normal operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_cnt[i]     <= {WIDTH{1'b0}};
            r_act_div[i] <= RST_DIV;
            r_shd_div[i] <= RST_DIV;
         end
         r_act_mode <= {CHANNELS{RST_MODE}};
         r_shd_mode <= {CHANNELS{RST_MODE}};
         r_pend     <= {CHANNELS{1'b0}};
         r_out      <= {CHANNELS{1'b0}};
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_cnt[i]     <= w_cnt[i];
            r_act_div[i] <= w_act_div[i];
            r_shd_div[i] <= w_shd_div[i];
         end
         r_act_mode <= w_act_mode;
         r_shd_mode <= w_shd_mode;
         r_pend     <= w_pend;
         r_out      <= w_out;
      end
   end

   assign divided = r_out;
   assign pending = r_pend;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Bench for prog_clock_divider: directed scenarios with fixed expectations, then
// randomized traffic compared every cycle against a behavioural channel model.
module tb_prog_clock_divider;
   localparam int CH = 4;
   localparam int W  = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          sync;
   logic          wr_en;
   logic          wr_mode;
   logic [CH-1:0] en;
   logic [1:0]    wr_chan;
   logic [W-1:0]  wr_div;
   logic [CH-1:0] divided;
   logic [CH-1:0] pending;

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_on   = 1'b0;

   // Model: cycles elapsed in the current period, active/shadow settings, output level.
   int m_phase [CH];
   int m_div   [CH];
   int m_sdiv  [CH];
   bit m_mode  [CH];
   bit m_smode [CH];
   bit m_pend  [CH];
   bit m_out   [CH];

   prog_clock_divider #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(1), .DEFAULT_MODE(1)) dut (
      .clk(clk), .rst(rst), .en(en), .sync(sync), .wr_en(wr_en), .wr_chan(wr_chan),
      .wr_div(wr_div), .wr_mode(wr_mode), .divided(divided), .pending(pending)
   );

   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   always @(posedge clk) begin : model
      bit mchg;
      for (int i = 0; i < CH; i++) begin
         if (rst) begin
            m_phase[i] = 0; m_div[i] = 1; m_sdiv[i] = 1;
            m_mode[i] = 1'b1; m_smode[i] = 1'b1; m_pend[i] = 1'b0; m_out[i] = 1'b0;
         end else begin
            mchg = m_pend[i] && (m_smode[i] != m_mode[i]);
            if (sync || (!en[i] && m_pend[i])) begin
               if (m_pend[i]) begin m_div[i] = m_sdiv[i]; m_mode[i] = m_smode[i]; end
               m_pend[i] = 1'b0; m_phase[i] = 0; m_out[i] = 1'b0;
            end else if (en[i]) begin
               if (m_phase[i] == m_div[i]) begin
                  if (m_pend[i]) begin m_div[i] = m_sdiv[i]; m_mode[i] = m_smode[i]; end
                  m_pend[i] = 1'b0;
                  m_phase[i] = 0;
                  m_out[i] = mchg ? 1'b0 : (m_mode[i] ? 1'b1 : !m_out[i]);
               end else begin
                  m_phase[i] = m_phase[i] + 1;
                  if (m_mode[i]) m_out[i] = 1'b0;
               end
            end else begin
               if (m_mode[i]) m_out[i] = 1'b0;
            end
            if (wr_en && (int'(wr_chan) == i)) begin
               m_sdiv[i] = int'(wr_div); m_smode[i] = wr_mode; m_pend[i] = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         for (int i = 0; i < CH; i++) begin
            check_value($sformatf("model_divided%0d", i), divided[i], m_out[i]);
            check_value($sformatf("model_pending%0d", i), pending[i], m_pend[i]);
         end
      end
   end

   task automatic write_ch(input int ch, input int d, input bit mode);
      wr_en = 1'b1; wr_chan = 2'(ch); wr_div = W'(d); wr_mode = mode;
   endtask

   initial begin
      int n;
      int highs;
      rst = 1'b1; sync = 1'b0; wr_en = 1'b0; wr_chan = 2'd0; wr_div = 16'd0; wr_mode = 1'b0;
      en = 4'b0000;
      @(negedge clk); @(negedge clk);
      chk_on = 1'b1;
      check_value("reset_divided", divided, 32'd0);
      check_value("reset_pending", pending, 32'd0);

      // Default D=1 pulse: high after edge 2 and every second edge after that.
      rst = 1'b0; en = 4'b1111;
      @(negedge clk); check_value("t1_edge1", divided[0], 32'd0);
      @(negedge clk); check_value("t1_edge2", divided[0], 32'd1);
      @(negedge clk); check_value("t1_edge3", divided[0], 32'd0);
      @(negedge clk); check_value("t1_edge4", divided[0], 32'd1);

      // Channel 1 to toggle, D=3: pending until applied, then 8-cycle 50% wave.
      write_ch(1, 3, 1'b0);
      @(negedge clk); wr_en = 1'b0;
      check_value("t2_pending_set", pending[1], 32'd1);
      n = 0;
      while (pending[1] && n < 10) begin @(negedge clk); n++; end
      check_value("t2_applied", pending[1], 32'd0);
      highs = 0;
      for (int k = 0; k < 16; k++) begin
         if (divided[1]) highs++;
         @(negedge clk);
      end
      check_value("t2_high_count", highs, 32'd8);

      // Channel 2 D=9, rewrite to D=2 mid-period: full 10-cycle period, then 3.
      write_ch(2, 9, 1'b1);
      @(negedge clk); wr_en = 1'b0;
      n = 0;
      while (pending[2] && n < 20) begin @(negedge clk); n++; end
      n = 0;
      while (!divided[2] && n < 30) begin @(negedge clk); n++; end
      check_value("t3_sync_pulse", divided[2], 32'd1);
      n = 0;
      do begin
         @(negedge clk); n++;
         wr_en = (n == 5); wr_chan = 2'd2; wr_div = 16'd2; wr_mode = 1'b1;
      end while (!divided[2] && n < 200);
      wr_en = 1'b0;
      check_value("t3_long_period", n, 32'd10);
      n = 0;
      do begin @(negedge clk); n++; end while (!divided[2] && n < 200);
      check_value("t3_short_period", n, 32'd3);

      // Disabled channel 3 applies its write on the next edge; resumes from zero.
      en[3] = 1'b0; write_ch(3, 4, 1'b1);
      @(negedge clk); wr_en = 1'b0;
      check_value("t4_pending_set", pending[3], 32'd1);
      @(negedge clk);
      check_value("t4_pending_clear", pending[3], 32'd0);
      en[3] = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!divided[3] && n < 200);
      check_value("t4_first_pulse", n, 32'd5);
      n = 0;
      do begin @(negedge clk); n++; end while (!divided[3] && n < 200);
      check_value("t4_period", n, 32'd5);

      // D=2/4/6 on channels 0..2, sync: coincident pulses first at edge 105.
      write_ch(0, 2, 1'b1); @(negedge clk);
      write_ch(1, 4, 1'b1); @(negedge clk);
      write_ch(2, 6, 1'b1); @(negedge clk);
      wr_en = 1'b0;
      repeat ($urandom_range(3, 12)) @(negedge clk);
      sync = 1'b1;
      @(negedge clk); sync = 1'b0;
      check_value("t5_sync_divided", divided[2:0], 32'd0);
      check_value("t5_sync_pending", pending, 32'd0);
      n = 0;
      do begin @(negedge clk); n++; end while (divided[2:0] != 3'b111 && n < 300);
      check_value("t5_coincidence", n, 32'd105);

      // Reset mid-period with channel 1 in toggle mode, then rst with sync and a write.
      write_ch(1, 3, 1'b0); @(negedge clk); wr_en = 1'b0;
      n = 0;
      while (!divided[1] && n < 40) begin @(negedge clk); n++; end
      check_value("t6_toggle_high", divided[1], 32'd1);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      check_value("t6_rst_divided", divided, 32'd0);
      check_value("t6_rst_pending", pending, 32'd0);
      @(negedge clk); check_value("t6_default_edge1", divided, 32'd0);
      @(negedge clk); check_value("t6_default_edge2", divided, 32'd15);
      rst = 1'b1; sync = 1'b1; write_ch(0, 5, 1'b0);
      @(negedge clk); rst = 1'b0; sync = 1'b0; wr_en = 1'b0;
      check_value("t6_rst_sync_wr_pending", pending, 32'd0);
      check_value("t6_rst_sync_wr_divided", divided, 32'd0);

      // Randomized traffic, checked every cycle against the model.
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < CH; i++) en[i] = ($urandom_range(0, 9) != 0);
         wr_en   = ($urandom_range(0, 3) == 0);
         wr_chan = 2'($urandom_range(0, 3));
         wr_div  = W'($urandom_range(0, 6));
         wr_mode = 1'($urandom_range(0, 1));
         sync    = ($urandom_range(0, 49) == 0);
         rst     = ($urandom_range(0, 299) == 0);
         @(negedge clk);
      end
      rst = 1'b0; sync = 1'b0; wr_en = 1'b0; en = 4'b1111;
      @(negedge clk);
      chk_on = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
